inst_buffer: RTL and testbench
==============================

# inst_buffer

Instruction buffer between the branch predictor (BP) and decode/dispatch. It accepts up to `N` predicted fetch packets per cycle from BP into a circular FIFO and presents the oldest up to `N` entries, in program order, to dispatch. Fetch is decoupled from dispatch stalls through a registered stall/free-count signal. On a squash (mispredict recovery) the buffer discards every held and incoming packet.

## Interface
Parameters:
- `N`, default `` `N ``: superscalar width; number of lanes in and out.
- `DEPTH`, default 8: buffer entries. Must be a power of two and ≥ `N`.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset. `reset==0` at a rising edge clears all state.
- `bp_packet_in`  in  `[N-1:0]` IF_ID_PACKET  predicted packets from BP, lane 0 oldest; `valid`, `inst`, `PC`, `NPC` per lane.
- `squash_in`  in  1  flush request from mispredict recovery.
- `dispatch_num_in`  in  `$clog2(N+1)`  number of packets dispatch consumes this cycle (0..N).
- `ib_packet_out`  out  `[N-1:0]` IF_ID_PACKET  oldest entries, lane 0 = head.
- `ib_free_out`  out  `$clog2(DEPTH+1)`  free entries, registered.
- `ib_stall_out`  out  1  to fetch/BP: 1 when `ib_free_out < N`.

## Operation
- State: `head` and `tail` (`$clog2(DEPTH)` bits, wrap modulo DEPTH), `count` (`$clog2(DEPTH+1)` bits), and an entry array of IF_ID_PACKET.
- Enqueue is accepted only when `ib_stall_out==0` and `squash_in==0`. Otherwise all of `bp_packet_in` is dropped; fetch must hold and re-present the packets.
- Valid lanes are compacted in lane order. The k-th valid lane (k from 0) is written to `entry[tail+k]`. `enq = popcount(valid)`. Invalid lanes consume no entry.
- Dequeue: `deq = min(dispatch_num_in, count)`. `head` advances by `deq`. A `dispatch_num_in > count` is clamped and is not an error.
- `ib_packet_out[i]` = `entry[(head+i) mod DEPTH]`, with `valid = (i < count) && !squash_in`. When `valid=0`, the other fields are don't-care.
- Update when not squashing: `tail += enq`, `count = count + enq - deq`.
- The stall decision uses `count` from before the dequeue, which is conservative. Overflow is therefore impossible: `enq ≤ N ≤ free`.
- Squash: at the edge, `head = tail = count = 0`. Incoming packets and any dequeue in that cycle are ignored.
- Priority: reset > squash > normal enqueue/dequeue.
- `ib_free_out = DEPTH - count`. `ib_stall_out = (DEPTH - count) < N`. Both are derived from registered `count` only, with no combinational path from inputs.

## Timing
- Reset values: `head = tail = count = 0`; every `ib_packet_out[i].valid = 0`; `ib_free_out = DEPTH`; `ib_stall_out = 0`. Entry contents are don't-care.
- Latency: a packet enqueued at edge t is visible on `ib_packet_out` after edge t (one-cycle latency).
- Output data is combinational from registered state and available at the start of the cycle. `valid` additionally depends on `squash_in` (same-cycle masking).
- Dispatch samples `ib_packet_out` and asserts `dispatch_num_in` in the same cycle. The entries are removed at the following edge.
- Full (`count == DEPTH`): `ib_free_out = 0`, stall = 1. Dequeue still operates.
- Empty: all outputs invalid, and `deq` = 0 regardless of `dispatch_num_in`.
- Simultaneous enqueue and dequeue at `count == DEPTH-N+1`: stall = 1, so only the dequeue occurs.
- Wrap-around: pointer arithmetic is modulo DEPTH. Output lanes spanning index DEPTH-1 → 0 must be in order.
- Reset deasserted mid-operation: buffer restarts empty. No partial state survives.

## Test plan
- Reset with `reset=0` for one edge → all outputs invalid, `ib_free_out=8`, `ib_stall_out=0` (N=3, DEPTH=8).
- Enqueue 3 NOP packets with PC 0x4/0x8/0xC and NPC 0x8/0xC/0x10, `dispatch_num_in=0` → next cycle, out lanes 0..2 valid with PC 0x4/0x8/0xC; `ib_free_out=5`.
- Sparse lanes: only lane 1 (JAL, PC 0x4, NPC 0x18) valid into an empty buffer → next cycle lane 0 holds PC 0x4/NPC 0x18 and lanes 1..2 are invalid; `count=1`.
- Fill: enqueue 3+3 with no dispatch → `ib_free_out=2`, stall=1. A further enqueue is dropped (count stays 6). Then `dispatch_num_in=3` → free=5, stall=0 next cycle.
- Wrap: cycle more than 8 entries through the buffer with dispatch 2 and enqueue 2 per cycle → output PCs are strictly sequential across the index 7→0 boundary.
- Squash with a simultaneous valid enqueue and `dispatch_num_in=3` → outputs invalid in that same cycle; next cycle `count=0`, `free=8`, and no incoming packet is retained.

Source files
------------

// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - instruction buffer between branch predictor and dispatch
//
// Circular FIFO of fetch packets. Up to N packets enter per cycle (valid lanes
// compacted in lane order), the oldest up to N leave per cycle in program order.
//
// Packet layout (PKT_W = 97 bits, MSB first): {valid, inst[31:0], PC[31:0], NPC[31:0]}
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   synchronous active-low reset
//   bp_packet_in     in   [N][PKT_W] packets from BP, lane 0 oldest
//   squash_in        in   flush all held and incoming packets
//   dispatch_num_in  in   packets consumed by dispatch this cycle (0..N)
//   ib_packet_out    out  [N][PKT_W] oldest entries, lane 0 = head
//   ib_free_out      out  free entries, from registered count only
//   ib_stall_out     out  1 when fewer than N entries are free

`ifndef N
`define N 3
`endif

module inst_buffer #(
  parameter int N     = `N,
  parameter int DEPTH = 8,
  localparam int PKT_W = 97,
  localparam int DN_W  = $clog2(N + 1),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N-1:0][PKT_W-1:0]    bp_packet_in,
  input  logic                       squash_in,
  input  logic [DN_W-1:0]            dispatch_num_in,
  output logic [N-1:0][PKT_W-1:0]    ib_packet_out,
  output logic [CNT_W-1:0]           ib_free_out,
  output logic                       ib_stall_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] N_C     = CNT_W'(N);

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } pkt_t;

  // Registered state
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  pkt_t             r_entry [DEPTH];

  // Combinational helpers
  logic [CNT_W-1:0] w_free;
  logic             w_stall;
  logic             w_enq_ok;
  logic [PTR_W-1:0] w_lane_off [N];
  logic [CNT_W-1:0] w_enq;
  logic [CNT_W-1:0] w_enq_eff;
  logic [CNT_W-1:0] w_disp;
  logic [CNT_W-1:0] w_deq;
  pkt_t             w_in [N];

  // Free space and stall come from the registered count alone, so fetch never
  // sees a combinational path from this cycle's dispatch or squash.
  assign w_free   = DEPTH_C - r_count;
  assign w_stall  = (w_free < N_C);
  assign w_enq_ok = !w_stall && !squash_in;

  assign ib_free_out  = w_free;
  assign ib_stall_out = w_stall;

  // Compaction: each valid lane lands at tail + (number of valid lanes before it).
  always_comb begin
    logic [CNT_W-1:0] v_run;
    v_run = '0;
    for (int i = 0; i < N; i++) begin
      w_in[i]       = pkt_t'(bp_packet_in[i]);
      w_lane_off[i] = PTR_W'(v_run);
      if (w_in[i].valid) begin
        v_run = v_run + CNT_W'(1);
      end
    end
    w_enq = v_run;
  end

  assign w_enq_eff = w_enq_ok ? w_enq : '0;

  // Dispatch requests beyond the held count are clamped, not flagged.
  assign w_disp = CNT_W'(dispatch_num_in);
  assign w_deq  = (w_disp < r_count) ? w_disp : r_count;

  // Output window: oldest N entries; squash masks validity in the same cycle.
  always_comb begin
    pkt_t             v_pkt;
    logic [PTR_W-1:0] v_idx;
    ib_packet_out = '0;
    for (int i = 0; i < N; i++) begin
      v_idx         = r_head + PTR_W'(i);
      v_pkt         = r_entry[v_idx];
      v_pkt.valid   = (CNT_W'(i) < r_count) && !squash_in;
      ib_packet_out[i] = v_pkt;
    end
  end

  // Pointer and occupancy update. Reset outranks squash, squash outranks traffic.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (squash_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq);
      r_tail  <= r_tail + PTR_W'(w_enq_eff);
      r_count <= r_count + w_enq_eff - w_deq;
    end
  end

  // Entry storage carries no reset; contents outside [head, head+count) are dead.
  always_ff @(posedge clock) begin
    if (reset && w_enq_ok) begin
      for (int i = 0; i < N; i++) begin
        if (w_in[i].valid) begin
          r_entry[r_tail + w_lane_off[i]] <= w_in[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - directed table-driven bench for inst_buffer (N=3, DEPTH=8)
module tb_inst_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JAL = 32'h0140_00ef;

  logic                clock;
  logic                reset;
  logic [2:0][96:0]    bp_in;
  logic                squash;
  logic [1:0]          disp;
  logic [2:0][96:0]    ib_out;
  logic [3:0]          free_out;
  logic                stall_out;

  int n_checks;
  int n_fail;

  inst_buffer #(.N(3), .DEPTH(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .bp_packet_in    (bp_in),
    .squash_in       (squash),
    .dispatch_num_in (disp),
    .ib_packet_out   (ib_out),
    .ib_free_out     (free_out),
    .ib_stall_out    (stall_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0][96:0] in;
    logic             sq;
    logic [1:0]       d;
    logic [2:0]       ev;
    logic [31:0]      epc [3];
    logic [31:0]      enpc0;
    logic [3:0]       efree;
    logic             estall;
  } vec_t;

  vec_t tv [$];

  function automatic logic [96:0] pk(input logic v, input logic [31:0] inst,
                                     input logic [31:0] pc, input logic [31:0] npc);
    return {v, inst, pc, npc};
  endfunction

  function automatic logic [96:0] nop(input logic [31:0] pc);
    return pk(1'b1, NOP, pc, pc + 32'd4);
  endfunction

  function automatic vec_t mkv(input logic [96:0] l0, input logic [96:0] l1,
                               input logic [96:0] l2, input logic sq,
                               input logic [1:0] d, input logic [2:0] ev,
                               input logic [31:0] p0, input logic [31:0] p1,
                               input logic [31:0] p2, input logic [31:0] n0,
                               input logic [3:0] fr, input logic st);
    vec_t v;
    v.in[0] = l0; v.in[1] = l1; v.in[2] = l2;
    v.sq = sq; v.d = d; v.ev = ev;
    v.epc[0] = p0; v.epc[1] = p1; v.epc[2] = p2;
    v.enpc0 = n0; v.efree = fr; v.estall = st;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [2:0] valids();
    logic [2:0] v;
    for (int i = 0; i < 3; i++) v[i] = ib_out[i][96];
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; squash = 1'b0; disp = 2'd0; bp_in = '0;
    tick();
    reset = 1'b1;
  endtask

  localparam logic [96:0] Z = '0;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0; squash = 1'b0; disp = 2'd0; bp_in = '0;
    #1;
    do_reset();
    #1;
    chk("reset_valid", 0, 32'(valids()), 32'd0);
    chk("reset_free",  0, 32'(free_out), 32'd8);
    chk("reset_stall", 0, 32'(stall_out), 32'd0);

    // Outputs expected before the edge; the row's inputs act at that edge.
    tv.push_back(mkv(nop(32'h4), nop(32'h8), nop(32'hC), 0, 0, 3'b000, 0, 0, 0, 0, 8, 0));
    tv.push_back(mkv(Z, Z, Z, 0, 0, 3'b111, 32'h4, 32'h8, 32'hC, 32'h8, 5, 0));
    tv.push_back(mkv(Z, Z, Z, 0, 3, 3'b111, 32'h4, 32'h8, 32'hC, 32'h8, 5, 0));
    tv.push_back(mkv(Z, pk(1, JAL, 32'h4, 32'h18), Z, 0, 0, 3'b000, 0, 0, 0, 0, 8, 0));
    tv.push_back(mkv(Z, Z, Z, 0, 0, 3'b001, 32'h4, 0, 0, 32'h18, 7, 0));
    tv.push_back(mkv(Z, Z, Z, 0, 3, 3'b001, 32'h4, 0, 0, 32'h18, 7, 0));
    tv.push_back(mkv(Z, Z, Z, 0, 2, 3'b000, 0, 0, 0, 0, 8, 0));
    tv.push_back(mkv(nop(32'h100), nop(32'h104), nop(32'h108), 0, 0, 3'b000, 0, 0, 0, 0, 8, 0));
    tv.push_back(mkv(nop(32'h10C), nop(32'h110), nop(32'h114), 0, 0, 3'b111,
                     32'h100, 32'h104, 32'h108, 32'h104, 5, 0));
    tv.push_back(mkv(nop(32'h200), nop(32'h204), nop(32'h208), 0, 0, 3'b111,
                     32'h100, 32'h104, 32'h108, 32'h104, 2, 1));
    tv.push_back(mkv(Z, Z, Z, 0, 3, 3'b111, 32'h100, 32'h104, 32'h108, 32'h104, 2, 1));
    tv.push_back(mkv(Z, Z, Z, 0, 0, 3'b111, 32'h10C, 32'h110, 32'h114, 32'h110, 5, 0));
    tv.push_back(mkv(nop(32'h118), nop(32'h11C), nop(32'h120), 0, 1, 3'b111,
                     32'h10C, 32'h110, 32'h114, 32'h110, 5, 0));
    tv.push_back(mkv(nop(32'h124), nop(32'h128), nop(32'h12C), 0, 0, 3'b111,
                     32'h110, 32'h114, 32'h118, 32'h114, 3, 0));
    tv.push_back(mkv(nop(32'h300), nop(32'h304), nop(32'h308), 0, 0, 3'b111,
                     32'h110, 32'h114, 32'h118, 32'h114, 0, 1));
    tv.push_back(mkv(nop(32'h400), nop(32'h404), nop(32'h408), 1, 3, 3'b000, 0, 0, 0, 0, 0, 1));
    tv.push_back(mkv(Z, Z, Z, 0, 0, 3'b000, 0, 0, 0, 0, 8, 0));
    tv.push_back(mkv(nop(32'h500), Z, nop(32'h504), 0, 0, 3'b000, 0, 0, 0, 0, 8, 0));
    tv.push_back(mkv(nop(32'h508), nop(32'h50C), nop(32'h510), 0, 0, 3'b011,
                     32'h500, 32'h504, 0, 32'h504, 6, 0));
    tv.push_back(mkv(nop(32'h514), Z, Z, 0, 0, 3'b111, 32'h500, 32'h504, 32'h508, 32'h504, 3, 0));
    tv.push_back(mkv(nop(32'h600), nop(32'h604), nop(32'h608), 0, 2, 3'b111,
                     32'h500, 32'h504, 32'h508, 32'h504, 2, 1));
    tv.push_back(mkv(Z, Z, Z, 0, 0, 3'b111, 32'h508, 32'h50C, 32'h510, 32'h50C, 4, 0));

    for (int v = 0; v < tv.size(); v++) begin
      bp_in  = tv[v].in;
      squash = tv[v].sq;
      disp   = tv[v].d;
      #1;
      chk("vec_valid", v, 32'(valids()), 32'(tv[v].ev));
      chk("vec_free",  v, 32'(free_out), 32'(tv[v].efree));
      chk("vec_stall", v, 32'(stall_out), 32'(tv[v].estall));
      for (int l = 0; l < 3; l++) begin
        if (tv[v].ev[l]) chk("vec_pc", v * 4 + l, ib_out[l][63:32], tv[v].epc[l]);
      end
      if (tv[v].ev[0]) chk("vec_npc0", v, ib_out[0][31:0], tv[v].enpc0);
      tick();
    end

    // Reset while holding data and with a valid enqueue: nothing survives.
    reset = 1'b0; squash = 1'b0; disp = 2'd0;
    bp_in[0] = nop(32'h700); bp_in[1] = nop(32'h704); bp_in[2] = nop(32'h708);
    tick();
    reset = 1'b1; bp_in = '0;
    #1;
    chk("midrst_valid", 0, 32'(valids()), 32'd0);
    chk("midrst_free",  0, 32'(free_out), 32'd8);
    bp_in[0] = nop(32'h710);
    tick();
    bp_in = '0;
    #1;
    chk("midrst_valid", 1, 32'(valids()), 32'b001);
    chk("midrst_pc",    1, ib_out[0][63:32], 32'h710);
    chk("midrst_free",  1, 32'(free_out), 32'd7);

    // Wrap: hold 3 entries while 2 enter and 2 leave each cycle; the window
    // crosses index 7->0 repeatedly.
    do_reset();
    bp_in[0] = nop(32'h1000); bp_in[1] = nop(32'h1004); bp_in[2] = nop(32'h1008);
    tick();
    for (int k = 0; k < 10; k++) begin
      bp_in[0] = nop(32'h100C + 32'(8 * k));
      bp_in[1] = nop(32'h1010 + 32'(8 * k));
      bp_in[2] = Z;
      disp = 2'd2;
      #1;
      chk("wrap_valid", k, 32'(valids()), 32'b111);
      chk("wrap_free",  k, 32'(free_out), 32'd5);
      for (int l = 0; l < 3; l++)
        chk("wrap_pc", k * 4 + l, ib_out[l][63:32], 32'h1000 + 32'(8 * k + 4 * l));
      tick();
    end
    bp_in = '0; disp = 2'd0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
